// File: rtl/fifo_stream_drain.sv
// Read-side drain for fifo_sync: pops words into a 2-entry skid buffer and presents them as a
// valid/ready stream. Define FIFO_STREAM_DRAIN_BURST_EN for burst counters, the STOP state and m_last.
module fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_cs_o,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  if (BURST_LEN < 2) begin : g_burst_len_check
    $error("fifo_stream_drain: BURST_LEN must be at least 2");
  end

  state_e                state_q;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic       can_read;
  logic       accept;
  logic       wr;
  logic [2:0] occupancy;
  logic [2:0] room_limit;

`ifdef FIFO_STREAM_DRAIN_BURST_EN
  localparam int unsigned CntW = $clog2(BURST_LEN);
  localparam logic [CntW-1:0] CntMax = CntW'(BURST_LEN - 1);
  localparam state_e RunExit = STOP;

  logic [CntW-1:0] issued_q;
  logic [CntW-1:0] out_q;

  // STOP keeps popping until the current burst has been fully read from the FIFO
  assign can_read = (state_q == RUN) | ((state_q == STOP) & (issued_q != '0));
  assign m_last_o = m_valid_o & (out_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q <= '0;
      out_q    <= '0;
    end else begin
      if (fifo_rd_en_o) begin
        issued_q <= (issued_q == CntMax) ? '0 : issued_q + CntW'(1);
      end
      if (accept) begin
        out_q <= (out_q == CntMax) ? '0 : out_q + CntW'(1);
      end
    end
  end
`else
  localparam state_e RunExit = IDLE;

  assign can_read = (state_q == RUN);
  assign m_last_o = 1'b0;
`endif

  assign wr        = inflight_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = head_q;
  assign accept    = m_valid_o & m_ready_i;
  assign busy_o    = (state_q != IDLE) | (count_q != 2'd0) | inflight_q;

  // Words already buffered or in flight, against the room left after this cycle's accept
  assign occupancy    = 3'(count_q) + 3'(inflight_q);
  assign room_limit   = 3'd2 + 3'(accept);
  assign fifo_rd_en_o = can_read & ~fifo_empty_i & (occupancy < room_limit);
  assign fifo_cs_o    = fifo_rd_en_o;

  // Two-entry buffer; head is always the oldest word
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({wr, accept})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = fifo_data_i;
        end else begin
          tail_d = fifo_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = fifo_data_i;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en_o;
      unique case (state_q)
        IDLE: if (enable_i) state_q <= RUN;
        RUN:  if (!enable_i) state_q <= RunExit;
`ifdef FIFO_STREAM_DRAIN_BURST_EN
        STOP: begin
          if (enable_i) begin
            state_q <= RUN;
          end else if (issued_q == '0) begin
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a queue-based FIFO feeds the DUT and a scoreboard predicts the stream.
// Burst framing expectations follow FIFO_STREAM_DRAIN_BURST_EN.
module tb_fifo_stream_drain;

  localparam int unsigned DW = 32;
  localparam int BL = 4;
`ifdef FIFO_STREAM_DRAIN_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif
  localparam int IdleM = 0;
  localparam int RunM  = 1;
  localparam int StopM = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic          fifo_cs, fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] push_q[$];
  exp_t          exp_q[$];
  bit            pop_s = 1'b0;
  bit            mon_on = 1'b0;
  int            cyc = 0;
  int            pop_cnt = 0;
  int            acc_cnt = 0;
  int            mode = IdleM;
  int            n_checks = 0;
  int            n_errors = 0;

  fifo_stream_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_cs_o   (fifo_cs),
    .fifo_rd_en_o(fifo_rd_en),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream FIFO with one-cycle registered read data and registered empty flag
  always @(posedge clk) begin
    if (pop_s && fq.size() != 0) begin
      fifo_data <= fq[0];
      fq.delete(0);
    end
    while (push_q.size() != 0) begin
      fq.push_back(push_q[0]);
      push_q.delete(0);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Reference model: a popped word is visible two cycles after its pop and leaves in order
  always @(negedge clk) begin : monitor
    bit   exp_valid, exp_rd, exp_busy, exp_last, can_rd, acc_exp, pop;
    int   nxt;
    exp_t e;
    cyc++;
    exp_valid = (exp_q.size() != 0) && (exp_q[0].cyc + 2 <= cyc);
    can_rd    = (mode == RunM) || (mode == StopM && (pop_cnt % BL) != 0);
    acc_exp   = exp_valid && m_ready;
    exp_rd    = can_rd && !fifo_empty && (exp_q.size() - int'(acc_exp) < 2);
    exp_busy  = (mode != IdleM) || (exp_q.size() != 0);
    exp_last  = BurstEn && exp_valid && ((acc_cnt % BL) == BL - 1);
    if (mon_on) begin
      check_eq("mon_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
      check_eq("mon_cs", 64'(fifo_cs), 64'(exp_rd));
      check_eq("mon_valid", 64'(m_valid), 64'(exp_valid));
      check_eq("mon_busy", 64'(busy), 64'(exp_busy));
      check_eq("mon_last", 64'(m_last), 64'(exp_last));
      if (exp_valid) check_eq("mon_data", 64'(m_data), 64'(exp_q[0].data));
    end
    pop = fifo_rd_en && !fifo_empty;
    nxt = mode;
    case (mode)
      IdleM: if (enable) nxt = RunM;
      RunM:  if (!enable) nxt = BurstEn ? StopM : IdleM;
      default: begin
        if (enable) nxt = RunM;
        else if ((pop_cnt % BL) == 0) nxt = IdleM;
      end
    endcase
    if (m_valid && m_ready && exp_q.size() != 0) begin
      exp_q.delete(0);
      acc_cnt++;
    end
    if (pop && fq.size() != 0) begin
      e.data = fq[0];
      e.cyc  = cyc;
      exp_q.push_back(e);
      pop_cnt++;
    end
    pop_s = fifo_rd_en;
    mode  = nxt;
    if (rst) begin
      mode    = IdleM;
      pop_cnt = 0;
      acc_cnt = 0;
      exp_q.delete();
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    tick();
    fq.delete();
    push_q.delete();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    mon_on = 1'b1;
    check_eq("rst_valid", 64'(m_valid), 64'(0));
    check_eq("rst_data", 64'(m_data), 64'(0));
    check_eq("rst_last", 64'(m_last), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_rd_en", 64'(fifo_rd_en), 64'(0));

    // Idle with data waiting: nothing may be read
    push_q.push_back(32'd1);
    push_q.push_back(32'd10);
    push_q.push_back(32'd100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_rd_en", 64'(fifo_rd_en), 64'(0));
    end
    check_eq("idle_valid", 64'(m_valid), 64'(0));
    check_eq("idle_busy", 64'(busy), 64'(0));

    // Streaming latency: read at cycle 1, first word out at cycle 3
    enable  = 1'b1;
    m_ready = 1'b1;
    tick();
    check_eq("lat_rd_en_c1", 64'(fifo_rd_en), 64'(1));
    tick();
    check_eq("lat_valid_c2", 64'(m_valid), 64'(0));
    tick();
    check_eq("lat_valid_c3", 64'(m_valid), 64'(1));
    check_eq("lat_data_c3", 64'(m_data), 64'(1));
    tick();
    check_eq("lat_data_c4", 64'(m_data), 64'(10));
    check_eq("lat_last_c4", 64'(m_last), 64'(0));
    tick();
    check_eq("lat_data_c5", 64'(m_data), 64'(100));
    check_eq("lat_last_c5", 64'(m_last), 64'(0));
    enable = 1'b0;

    // Backpressure: only two pops fit while stalled
    do_reset();
    for (int i = 0; i < 8; i++) push_q.push_back(DW'(1) << i);
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("stall_pops", 64'(pop_cnt), 64'(2));
    check_eq("stall_valid", 64'(m_valid), 64'(1));
    check_eq("stall_data", 64'(m_data), 64'(1));
    m_ready = 1'b1;
    for (int k = 0; k < 40 && acc_cnt < 8; k++) tick();
    check_eq("bp_drained", 64'(acc_cnt), 64'(8));

    // Drop enable after five pops: burst mode finishes the burst, plain mode stops at once
    do_reset();
    for (int i = 0; i < 8; i++) push_q.push_back(32'h100 + 32'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 40 && pop_cnt < 5; k++) tick();
    enable = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    check_eq("stop_pops", 64'(pop_cnt), BurstEn ? 64'(8) : 64'(6));
    check_eq("stop_out", 64'(acc_cnt), BurstEn ? 64'(8) : 64'(6));
    check_eq("stop_idle", 64'(busy), 64'(0));

    // Empty FIFO while running, then a late write
    do_reset();
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("empty_rd_en", 64'(fifo_rd_en), 64'(0));
      check_eq("empty_valid", 64'(m_valid), 64'(0));
    end
    push_q.push_back(32'hABCD_1234);
    tick();
    check_eq("late_valid_c1", 64'(m_valid), 64'(0));
    tick();
    check_eq("late_valid_c2", 64'(m_valid), 64'(0));
    tick();
    check_eq("late_valid_c3", 64'(m_valid), 64'(1));
    check_eq("late_data_c3", 64'(m_data), 64'(32'hABCD_1234));

    // Reset with one word buffered and one in flight
    do_reset();
    for (int i = 0; i < 8; i++) push_q.push_back(32'h200 + 32'(i));
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 64'(m_valid), 64'(0));
    check_eq("midrst_data", 64'(m_data), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_rd_en", 64'(fifo_rd_en), 64'(0));
    check_eq("midrst_last", 64'(m_last), 64'(0));

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) push_q.push_back($urandom);
      tick();
    end
    rst     = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < BL; i++) push_q.push_back($urandom);
    for (int k = 0; k < 200 && busy; k++) tick();
    check_eq("final_idle", 64'(busy), 64'(0));
    check_eq("final_scoreboard", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
